ca3_phase_memory_n: RTL and testbench
=====================================

# ca3_phase_memory_n

- Parametrised, theta-gated Hebbian auto-associative memory of N_UNITS binary units.
- Learns the presented pattern once per theta peak and recalls from a partial cue once per theta trough, iterating to convergence.
- Weights saturate and optionally decay.
- Sits between the thalamic theta `hopf_oscillator` (`theta_x`) and the cortical columns (`phase_pattern`); all state advances only on `clk_en`, the 4 kHz update strobe.

## Interface
Parameters:
- WIDTH, 18, theta sample width (signed fixed point)
- FRAC, 14, theta fractional bits
- N_UNITS, 6, number of units / pattern bits (2..16)
- W_BITS, 6, signed weight width
- THETA_HI, 12288, peak threshold (learn)
- THETA_LO, -12288, trough threshold (recall)
- RECALL_ITERS, 4, maximum recall sweeps
- DECAY_PERIOD, 256, idle updates between decay steps

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- clk_en  in  1  update strobe; FSM and weights change only when high
- theta_x  in  WIDTH signed  theta oscillator x
- pattern_in  in  N_UNITS  training pattern or recall cue
- phase_pattern  out  N_UNITS  recalled pattern (registered)
- learning  out  1  high while in LEARN
- recalling  out  1  high while in RECALL
- converged  out  1  last recall ended on a sweep with no change
- debug_state  out  4  0 IDLE, 1 LEARN, 2 RECALL, 3 DECAY

## Operation
- **Weights:** N_UNITS×N_UNITS signed W_BITS matrix; the diagonal is forced to 0.
  - Bit b maps to bipolar s = +1 if 1, -1 if 0.
  - Updates saturate at ±(2^(W_BITS-1)-1).
- **Arming:** independent learn and recall arm flags, both set at reset.
  - learn_arm clears on a learn trigger and re-sets when theta_x < 0.
  - recall_arm clears on a recall trigger and re-sets when theta_x > 0.
  - Result: at most one learn per peak and one recall per trough.
- **IDLE → LEARN:** on a clk_en when theta_x >= THETA_HI, learn_arm = 1 and pattern_in != 0.
  - pattern_in is latched and row counter r = 0.
  - On each following clk_en, row r is updated: w_rj += s_r·s_j for j≠r, then r++.
  - After row N_UNITS-1, return to IDLE. LEARN lasts exactly N_UNITS updates.
- **IDLE → RECALL:** on a clk_en when theta_x <= THETA_LO, recall_arm = 1 and pattern_in != 0.
  - phase_pattern ← pattern_in, cue mask ← pattern_in, iter = 0.
  - Each following clk_en performs one synchronous sweep over all units:
    - h_i = Σ_j w_ij·s_j.
    - Unit i becomes 1 if h_i > 0 and 0 if h_i < 0; it holds if h_i = 0.
    - Units set in the cue mask stay clamped to 1.
  - Exit to IDLE after a sweep with no bit change (converged = 1) or after RECALL_ITERS sweeps (converged = 0).
- **Priority:** if both triggers are valid on the same update, learn wins. Triggers are ignored outside IDLE; arm flags are unaffected while ignored.
- **Accumulator width:** W_BITS + clog2(N_UNITS) + 1, signed. No overflow is possible.
- **pattern_in == 0** never triggers either operation.
- **Reset:** rst mid-operation aborts immediately and clears all weights, counters and outputs.

## Timing
- Reset values:
  - phase_pattern = 0, learning = 0, recalling = 0, converged = 0, debug_state = 0.
  - All weights = 0; both arm flags = 1; decay counter = 0.
- Trigger on clk_en k: state is registered at the end of cycle k, so learning/recalling go high on cycle k+1.
- learning stays high through the N_UNITS-th subsequent clk_en and drops the cycle after it.
- phase_pattern updates on the trigger clk_en (cue load) and then once per sweep.
- converged is valid from the cycle after RECALL exits and holds until the next recall trigger.
- Cycles with clk_en low freeze everything; outputs remain stable.
- Worst-case recall latency is RECALL_ITERS+1 updates after the trigger.

## Configuration
- **CA3_WEIGHT_DECAY_EN defined:**
  - The decay counter increments on each IDLE clk_en.
  - When it reaches DECAY_PERIOD-1, the next IDLE clk_en enters DECAY for one update: every nonzero weight moves 1 toward 0, the counter clears, then the FSM returns to IDLE.
  - A learn or recall trigger on that same update takes priority; the decay is deferred to the next IDLE update.
  - The counter pauses outside IDLE.
- **CA3_WEIGHT_DECAY_EN undefined:** no decay counter and no DECAY state; debug_state never reads 3 and weights change only in LEARN.

## Test plan
- **Reset:** assert rst for 5 cycles with clk_en toggling → all outputs 0, debug_state 0; recall with cue 100000 afterwards returns 100000 with converged = 1 after 1 sweep.
- **Learn timing:** drive theta_x = 13000 and pattern_in = 101010 → learning high for exactly 6 updates starting the cycle after the trigger; theta held high for 100 updates gives exactly one LEARN.
- **Recall:** train 101010 five times (alternate theta_x ±13000) → trough with cue 100000 yields phase_pattern = 101010, converged = 1, recalling high ≤ 5 updates.
- **Second pattern:** additionally train 010101 five times → cue 000100 yields 010101; cue 100000 still yields 101010.
- **Saturation:** W_BITS = 4, train 101010 twenty times, then train 111000 once → cue 100000 still recalls 101010, showing weights clamped at ±7 rather than wrapped.
- **Decay (macro on, DECAY_PERIOD = 16):** train 101010 once, idle 16 updates (debug_state pulses 3 once) → cue 100000 returns 100000; with the macro off the same sequence returns 101010.

Source files
------------

// File: rtl/ca3_phase_memory_n.sv
// ca3_phase_memory_n: theta-gated Hebbian auto-associative memory; learns at theta peaks, recalls at troughs.
// Optional weight decay is compiled in when CA3_WEIGHT_DECAY_EN is defined.
module ca3_phase_memory_n #(
  parameter int WIDTH        = 18,
  parameter int FRAC         = 14,
  parameter int N_UNITS      = 6,
  parameter int W_BITS       = 6,
  parameter int THETA_HI     = 12288,
  parameter int THETA_LO     = -12288,
  parameter int RECALL_ITERS = 4,
  parameter int DECAY_PERIOD = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] theta_x,
  input  logic [N_UNITS-1:0]      pattern_in,
  output logic [N_UNITS-1:0]      phase_pattern,
  output logic                    learning,
  output logic                    recalling,
  output logic                    converged,
  output logic [3:0]              debug_state
);

  localparam int ROW_W  = $clog2(N_UNITS);
  localparam int ITER_W = $clog2(RECALL_ITERS) + 1;
  localparam int ACC_W  = W_BITS + $clog2(N_UNITS) + 1;
  localparam logic signed [W_BITS-1:0] W_MAX = W_BITS'((1 << (W_BITS - 1)) - 1);
  localparam logic signed [W_BITS-1:0] W_ONE = W_BITS'(1);
  localparam logic signed [WIDTH-1:0]  TH_HI = WIDTH'(THETA_HI);
  localparam logic signed [WIDTH-1:0]  TH_LO = WIDTH'(THETA_LO);

  if (N_UNITS < 2 || N_UNITS > 16 || FRAC >= WIDTH || RECALL_ITERS < 1 || DECAY_PERIOD < 2)
  begin : g_bad_cfg
    $error("ca3_phase_memory_n: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LEARN  = 2'd1,
    S_RECALL = 2'd2,
    S_DECAY  = 2'd3
  } state_t;

  state_t                    r_state, w_state_next;
  logic signed [W_BITS-1:0]  r_w [N_UNITS][N_UNITS];
  logic [N_UNITS-1:0]        r_pattern, r_cue, r_train;
  logic [ROW_W-1:0]          r_row;
  logic [ITER_W-1:0]         r_iter;
  logic                      r_conv, r_learn_arm, r_recall_arm;
  logic [N_UNITS-1:0]        w_sweep;
  logic                      w_learn_go, w_recall_go, w_last_row, w_no_change, w_iter_last;
  logic                      w_decay_due;

  function automatic logic signed [W_BITS-1:0] hebb_step(input logic signed [W_BITS-1:0] w,
                                                         input logic agree);
    if (agree) return (w == W_MAX) ? w : w + W_ONE;
    return (w == -W_MAX) ? w : w - W_ONE;
  endfunction

  function automatic logic signed [W_BITS-1:0] toward_zero(input logic signed [W_BITS-1:0] w);
    if (w[W_BITS-1]) return w + W_ONE;
    if (w != '0)     return w - W_ONE;
    return w;
  endfunction

  assign w_learn_go  = (r_state == S_IDLE) && (theta_x >= TH_HI) && r_learn_arm && (|pattern_in);
  assign w_recall_go = (r_state == S_IDLE) && (theta_x <= TH_LO) && r_recall_arm && (|pattern_in)
                       && !w_learn_go;
  assign w_last_row  = (r_row == ROW_W'(N_UNITS - 1));
  assign w_no_change = (w_sweep == r_pattern);
  assign w_iter_last = (r_iter == ITER_W'(RECALL_ITERS - 1));

  // One synchronous sweep: every unit sees the bipolar field of the current pattern.
  always_comb begin : p_sweep
    logic signed [ACC_W-1:0] w_acc;
    w_sweep = r_pattern;
    w_acc   = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      w_acc = '0;
      for (int j = 0; j < N_UNITS; j++) begin
        if (j != i) w_acc = r_pattern[j] ? w_acc + ACC_W'(r_w[i][j]) : w_acc - ACC_W'(r_w[i][j]);
      end
      if (r_cue[i] || (!w_acc[ACC_W-1] && w_acc != '0)) w_sweep[i] = 1'b1;
      else if (w_acc[ACC_W-1])                            w_sweep[i] = 1'b0;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    learning     = (r_state == S_LEARN);
    recalling    = (r_state == S_RECALL);
    case (r_state)
      S_IDLE: begin
        if (w_learn_go)       w_state_next = S_LEARN;
        else if (w_recall_go) w_state_next = S_RECALL;
        else if (w_decay_due) w_state_next = S_DECAY;
      end
      S_LEARN:  if (w_last_row) w_state_next = S_IDLE;
      S_RECALL: if (w_no_change || w_iter_last) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)         r_state <= S_IDLE;
    else if (clk_en) r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the weights are flops, not a RAM, because reset must clear every one of them.
      for (int i = 0; i < N_UNITS; i++)
        for (int j = 0; j < N_UNITS; j++) r_w[i][j] <= '0;
      r_pattern    <= '0;
      r_cue        <= '0;
      r_train      <= '0;
      r_row        <= '0;
      r_iter       <= '0;
      r_conv       <= 1'b0;
      r_learn_arm  <= 1'b1;
      r_recall_arm <= 1'b1;
    end else if (clk_en) begin
      if (theta_x[WIDTH-1])                      r_learn_arm  <= 1'b1;
      if (!theta_x[WIDTH-1] && theta_x != '0)    r_recall_arm <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_learn_go) begin
            r_learn_arm <= 1'b0;
            r_train     <= pattern_in;
            r_row       <= '0;
          end else if (w_recall_go) begin
            r_recall_arm <= 1'b0;
            r_pattern    <= pattern_in;
            r_cue        <= pattern_in;
            r_iter       <= '0;
            r_conv       <= 1'b0;
          end
        end
        S_LEARN: begin
          // Only row r changes; the diagonal is never written and stays 0.
          for (int i = 0; i < N_UNITS; i++)
            for (int j = 0; j < N_UNITS; j++)
              if (ROW_W'(i) == r_row && i != j)
                r_w[i][j] <= hebb_step(r_w[i][j], r_train[i] == r_train[j]);
          r_row <= r_row + ROW_W'(1);
        end
        S_RECALL: begin
          r_pattern <= w_sweep;
          r_iter    <= r_iter + ITER_W'(1);
          if (w_no_change) r_conv <= 1'b1;
        end
        default: begin
`ifdef CA3_WEIGHT_DECAY_EN
          for (int i = 0; i < N_UNITS; i++)
            for (int j = 0; j < N_UNITS; j++) r_w[i][j] <= toward_zero(r_w[i][j]);
`endif
        end
      endcase
    end
  end

`ifdef CA3_WEIGHT_DECAY_EN
  localparam int DC_W = $clog2(DECAY_PERIOD);
  logic [DC_W-1:0] r_decay_cnt;

  // Counter holds at its last value while a trigger defers the decay step.
  assign w_decay_due = (r_decay_cnt == DC_W'(DECAY_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst) r_decay_cnt <= '0;
    else if (clk_en) begin
      if (r_state == S_DECAY)                     r_decay_cnt <= '0;
      else if (r_state == S_IDLE && !w_decay_due) r_decay_cnt <= r_decay_cnt + DC_W'(1);
    end
  end
`else
  assign w_decay_due = 1'b0;
`endif

  assign phase_pattern = r_pattern;
  assign converged     = r_conv;
  assign debug_state   = {2'b00, r_state};

endmodule

// File: tb/tb_ca3_phase_memory_n.sv
// Directed bench for ca3_phase_memory_n: three instances (default, 4-bit weights, short decay period)
// share one stimulus stream; each test task checks the instance it exercises.
module tb_ca3_phase_memory_n;

  logic               clk = 1'b0;
  logic               rst;
  logic               clk_en;
  logic signed [17:0] theta;
  logic [5:0]         pattern;

  logic [5:0] pp_a, pp_b, pp_c;
  logic       lrn_a, lrn_b, lrn_c, rec_a, rec_b, rec_c, cv_a, cv_b, cv_c;
  logic [3:0] dbg_a, dbg_b, dbg_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ca3_phase_memory_n #(.DECAY_PERIOD(4096)) u_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .theta_x(theta), .pattern_in(pattern),
    .phase_pattern(pp_a), .learning(lrn_a), .recalling(rec_a), .converged(cv_a), .debug_state(dbg_a));

  ca3_phase_memory_n #(.W_BITS(4), .DECAY_PERIOD(4096)) u_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .theta_x(theta), .pattern_in(pattern),
    .phase_pattern(pp_b), .learning(lrn_b), .recalling(rec_b), .converged(cv_b), .debug_state(dbg_b));

  ca3_phase_memory_n #(.DECAY_PERIOD(16)) u_c (
    .clk(clk), .rst(rst), .clk_en(clk_en), .theta_x(theta), .pattern_in(pattern),
    .phase_pattern(pp_c), .learning(lrn_c), .recalling(rec_c), .converged(cv_c), .debug_state(dbg_c));

  function automatic logic [5:0] pp_of(input int w);
    case (w) 0: return pp_a; 1: return pp_b; default: return pp_c; endcase
  endfunction
  function automatic logic rec_of(input int w);
    case (w) 0: return rec_a; 1: return rec_b; default: return rec_c; endcase
  endfunction
  function automatic logic cv_of(input int w);
    case (w) 0: return cv_a; 1: return cv_b; default: return cv_c; endcase
  endfunction

  // One update: clk_en high for one edge, then one frozen cycle; outputs sampled 1 time unit after edges.
  task automatic upd();
    clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (5) begin
      clk_en = ~clk_en;
      @(posedge clk); #1;
    end
    rst = 1'b0; clk_en = 1'b0;
  endtask

  task automatic train(input logic [5:0] p);
    theta = 18'sd13000; pattern = p;
    upd();
    pattern = '0;
    repeat (6) upd();
    theta = -18'sd13000;
    upd();
    theta = '0;
  endtask

  task automatic recall_run(input int which, input logic [5:0] cue, output logic [5:0] loaded,
                            output logic [5:0] pat, output logic cv, output int sweeps);
    theta = -18'sd13000; pattern = cue;
    upd();
    loaded = pp_of(which);
    pattern = '0;
    sweeps = 0;
    while (rec_of(which) && sweeps < 20) begin
      upd();
      sweeps++;
    end
    pat = pp_of(which);
    cv  = cv_of(which);
    theta = 18'sd1000;
    upd();
    theta = '0;
  endtask

  task automatic test_reset();
    logic [5:0] ld, pt; logic c; int n;
    theta = 18'sd13000; pattern = 6'b101010;
    upd();
    do_reset();
    theta = '0; pattern = '0;
    total++; if (pp_a !== 6'b0)  begin bad++; $display("FAIL reset_pattern got=%b want=000000", pp_a); end
    total++; if (lrn_a !== 1'b0) begin bad++; $display("FAIL reset_learning got=%b want=0", lrn_a); end
    total++; if (rec_a !== 1'b0) begin bad++; $display("FAIL reset_recalling got=%b want=0", rec_a); end
    total++; if (cv_a !== 1'b0)  begin bad++; $display("FAIL reset_converged got=%b want=0", cv_a); end
    total++; if (dbg_a !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_a); end
    recall_run(0, 6'b100000, ld, pt, c, n);
    total++; if (ld !== 6'b100000) begin bad++; $display("FAIL reset_cue_load got=%b want=100000", ld); end
    total++; if (pt !== 6'b100000) begin bad++; $display("FAIL reset_recall got=%b want=100000", pt); end
    total++; if (c !== 1'b1)       begin bad++; $display("FAIL reset_conv got=%b want=1", c); end
    total++; if (n != 1)           begin bad++; $display("FAIL reset_sweeps got=%0d want=1", n); end
  endtask

  task automatic test_learn_timing();
    int high, rises; logic prev, first;
    do_reset();
    theta = 18'sd13000; pattern = 6'b101010;
    high = 0; rises = 0; prev = 1'b0; first = 1'b0;
    for (int i = 0; i < 100; i++) begin
      upd();
      if (i == 0) first = lrn_a;
      if (i == 2) begin
        repeat (5) @(posedge clk);
        #1;
        total++; if (dbg_a !== 4'd1) begin bad++; $display("FAIL freeze_state got=%0d want=1", dbg_a); end
      end
      if (lrn_a) high++;
      if (lrn_a && !prev) rises++;
      prev = lrn_a;
    end
    theta = '0; pattern = '0;
    total++; if (first !== 1'b1) begin bad++; $display("FAIL learn_start got=%b want=1", first); end
    total++; if (high != 6)      begin bad++; $display("FAIL learn_length got=%0d want=6", high); end
    total++; if (rises != 1)     begin bad++; $display("FAIL learn_once got=%0d want=1", rises); end
  endtask

  task automatic test_thresholds();
    int n;
    do_reset();
    pattern = 6'b000001;
    theta = 18'sd12287;  upd();
    total++; if (dbg_a !== 4'd0) begin bad++; $display("FAIL below_hi got=%0d want=0", dbg_a); end
    theta = 18'sd12288;  upd();
    total++; if (dbg_a !== 4'd1) begin bad++; $display("FAIL at_hi got=%0d want=1", dbg_a); end
    repeat (6) upd();
    total++; if (dbg_a !== 4'd0) begin bad++; $display("FAIL learn_exit got=%0d want=0", dbg_a); end
    theta = -18'sd12287; upd();
    total++; if (dbg_a !== 4'd0) begin bad++; $display("FAIL above_lo got=%0d want=0", dbg_a); end
    theta = -18'sd12288; upd();
    total++; if (dbg_a !== 4'd2) begin bad++; $display("FAIL at_lo got=%0d want=2", dbg_a); end
    pattern = '0; n = 0;
    while (rec_a && n < 20) begin upd(); n++; end
    theta = 18'sd1000; upd();
    theta = 18'sd13000; upd();
    total++; if (dbg_a !== 4'd0) begin bad++; $display("FAIL zero_learn got=%0d want=0", dbg_a); end
    theta = -18'sd13000; upd();
    total++; if (dbg_a !== 4'd0) begin bad++; $display("FAIL zero_recall got=%0d want=0", dbg_a); end
    theta = '0;
  endtask

  task automatic test_recall_two_patterns();
    logic [5:0] ld, pt; logic c; int n;
    do_reset();
    repeat (5) train(6'b101010);
    recall_run(0, 6'b100000, ld, pt, c, n);
    total++; if (ld !== 6'b100000) begin bad++; $display("FAIL recall1_load got=%b want=100000", ld); end
    total++; if (pt !== 6'b101010) begin bad++; $display("FAIL recall1_pattern got=%b want=101010", pt); end
    total++; if (c !== 1'b1)       begin bad++; $display("FAIL recall1_conv got=%b want=1", c); end
    total++; if (n != 2)           begin bad++; $display("FAIL recall1_sweeps got=%0d want=2", n); end
    repeat (5) train(6'b010101);
    recall_run(0, 6'b000100, ld, pt, c, n);
    total++; if (pt !== 6'b010101) begin bad++; $display("FAIL recall2_pattern got=%b want=010101", pt); end
    total++; if (c !== 1'b1)       begin bad++; $display("FAIL recall2_conv got=%b want=1", c); end
    recall_run(0, 6'b100000, ld, pt, c, n);
    total++; if (pt !== 6'b101010) begin bad++; $display("FAIL recall3_pattern got=%b want=101010", pt); end
  endtask

  task automatic test_saturation();
    logic [5:0] ld, pt; logic c; int n;
    do_reset();
    repeat (20) train(6'b101010);
    train(6'b111000);
    recall_run(1, 6'b100000, ld, pt, c, n);
    total++; if (pt !== 6'b101010) begin bad++; $display("FAIL sat_pattern got=%b want=101010", pt); end
    total++; if (c !== 1'b1)       begin bad++; $display("FAIL sat_conv got=%b want=1", c); end
  endtask

  task automatic test_decay();
    logic [5:0] ld, pt, exp_pat; logic c; int n, pulses, exp_pulses;
`ifdef CA3_WEIGHT_DECAY_EN
    exp_pat = 6'b100000; exp_pulses = 1;
`else
    exp_pat = 6'b101010; exp_pulses = 0;
`endif
    do_reset();
    train(6'b101010);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      upd();
      if (dbg_c == 4'd3) pulses++;
    end
    recall_run(2, 6'b100000, ld, pt, c, n);
    total++; if (pulses != exp_pulses) begin bad++; $display("FAIL decay_pulses got=%0d want=%0d", pulses, exp_pulses); end
    total++; if (pt !== exp_pat)       begin bad++; $display("FAIL decay_recall got=%b want=%b", pt, exp_pat); end
    total++; if (c !== 1'b1)           begin bad++; $display("FAIL decay_conv got=%b want=1", c); end
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b0; theta = '0; pattern = '0;
    do_reset();
    test_reset();
    test_learn_timing();
    test_thresholds();
    test_recall_two_patterns();
    test_saturation();
    test_decay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
